// File: rtl/mrpnwp_wr_sched_if.sv
// rtl/mrpnwp_wr_sched_if.sv - requester/core-port bundle for the write-port scheduler
interface mrpnwp_wr_sched_if #(
    parameter int WIDTH   = 32,
    parameter int NUMREQ  = 6,
    parameter int BITREQ  = 3,
    parameter int NUMWRPT = 3
);
    logic                      ready;
    logic [NUMREQ-1:0]         req_vld;
    logic [NUMREQ*WIDTH-1:0]   req_din;
    logic [NUMREQ-1:0]         req_gnt;
    logic [NUMWRPT-1:0]        write;
    logic [NUMWRPT*WIDTH-1:0]  din;
    logic [BITREQ-1:0]         ptr;

    modport slave (
        input  ready, req_vld, req_din,
        output req_gnt, write, din, ptr
    );

    modport master (
        output ready, req_vld, req_din,
        input  req_gnt, write, din, ptr
    );
endinterface

// File: rtl/mrpnwp_wr_sched.sv
// rtl/mrpnwp_wr_sched.sv - round-robin sharing of NUMWRPT core write ports among NUMREQ requesters
module mrpnwp_wr_sched #(
    parameter int WIDTH   = 32,
    parameter int NUMREQ  = 6,
    parameter int BITREQ  = 3,
    parameter int NUMWRPT = 3
) (
    input  logic clk,
    input  logic rst,
    mrpnwp_wr_sched_if.slave bus
);
    logic [NUMWRPT-1:0]       write_q, write_d;
    logic [NUMWRPT*WIDTH-1:0] din_q, din_d;
    logic [BITREQ-1:0]        ptr_q, ptr_d;
    logic [NUMREQ-1:0]        gnt;
    int                       slot, base, idx;

    // Scan offsets 0..NUMREQ-1 from ptr; the n-th hit lands on port n until ports run out.
    always_comb begin
        gnt     = '0;
        write_d = '0;
        din_d   = din_q;
        ptr_d   = ptr_q;
        slot    = 0;
        base    = int'(ptr_q);
        idx     = 0;
        for (int i = 0; i < NUMREQ; i++) begin
            idx = base + i;
            if (idx >= NUMREQ) idx = idx - NUMREQ;
            for (int j = 0; j < NUMREQ; j++) begin
                if (j == idx && bus.ready && !rst && bus.req_vld[j] && slot < NUMWRPT) begin
                    gnt[j] = 1'b1;
                    for (int k = 0; k < NUMWRPT; k++) begin
                        if (k == slot) begin
                            write_d[k]                = 1'b1;
                            din_d[k*WIDTH +: WIDTH]   = bus.req_din[j*WIDTH +: WIDTH];
                        end
                    end
                    ptr_d = (j == NUMREQ - 1) ? '0 : BITREQ'(j + 1);
                    slot  = slot + 1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= '0;
            din_q   <= '0;
            ptr_q   <= '0;
        end else begin
            write_q <= write_d;
            din_q   <= din_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.req_gnt = gnt;
    assign bus.write   = write_q;
    assign bus.din     = din_q;
    assign bus.ptr     = ptr_q;
endmodule

// File: tb/tb_mrpnwp_wr_sched.sv
// tb/tb_mrpnwp_wr_sched.sv - randomized and directed checks of mrpnwp_wr_sched against a queue-based model
module tb_mrpnwp_wr_sched;
    localparam int WIDTH = 32, NUMREQ = 6, BITREQ = 3, NUMWRPT = 3;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    mrpnwp_wr_sched_if #(.WIDTH(WIDTH), .NUMREQ(NUMREQ), .BITREQ(BITREQ), .NUMWRPT(NUMWRPT)) bus ();

    mrpnwp_wr_sched #(.WIDTH(WIDTH), .NUMREQ(NUMREQ), .BITREQ(BITREQ), .NUMWRPT(NUMWRPT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state: what the registered outputs must currently show.
    logic [NUMWRPT-1:0]       m_write;
    logic [NUMWRPT*WIDTH-1:0] m_din;
    int                       m_ptr;
    logic [NUMREQ-1:0]        m_gnt;
    int                       m_order[$];

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Who is granted, in port order, for the currently applied inputs.
    task automatic model_grants();
        m_order.delete();
        m_gnt = '0;
        if (!rst && bus.ready) begin
            for (int i = 0; i < NUMREQ; i++) begin
                int r;
                r = (m_ptr + i) % NUMREQ;
                if (bus.req_vld[r] && m_order.size() < NUMWRPT) m_order.push_back(r);
            end
        end
        foreach (m_order[n]) m_gnt[m_order[n]] = 1'b1;
    endtask

    task automatic set_din_default();
        for (int r = 0; r < NUMREQ; r++) bus.req_din[r*WIDTH +: WIDTH] = 32'hA0 + r;
    endtask

    task automatic apply(input logic r, input logic rd, input logic [NUMREQ-1:0] v);
        rst         = r;
        bus.ready   = rd;
        bus.req_vld = v;
        #1;
        model_grants();
        chk("gnt",   192'(bus.req_gnt), 192'(m_gnt));
        chk("write", 192'(bus.write),   192'(m_write));
        chk("din",   192'(bus.din),     192'(m_din));
        chk("ptr",   192'(bus.ptr),     192'(m_ptr));
    endtask

    // Clock edge: advance the model exactly as the rules state.
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            m_write = '0;
            m_din   = '0;
            m_ptr   = 0;
        end else begin
            m_write = '0;
            foreach (m_order[k]) begin
                m_write[k] = 1'b1;
                m_din[k*WIDTH +: WIDTH] = bus.req_din[m_order[k]*WIDTH +: WIDTH];
            end
            if (m_order.size() > 0) m_ptr = (m_order[m_order.size()-1] + 1) % NUMREQ;
        end
        #1;
    endtask

    int gcount[NUMREQ];
    int wtotal;

    initial begin
        rst = 1'b1;
        bus.ready = 1'b0;
        bus.req_vld = '0;
        set_din_default();
        m_write = '0; m_din = '0; m_ptr = 0;
        @(posedge clk); #1;
        apply(1, 1, 6'h3F);
        chk("reset_gnt", 192'(bus.req_gnt), 192'(0));
        adv();

        // Not ready: nothing granted, pointer parked.
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 6'h3F);
            chk("nr_gnt", 192'(bus.req_gnt), 192'(0));
            chk("nr_write", 192'(bus.write), 192'(0));
            chk("nr_ptr", 192'(bus.ptr), 192'(0));
            adv();
        end

        apply(0, 1, 6'h3F);
        chk("t2_gnt0", 192'(bus.req_gnt), 192'(6'b000111));
        adv();
        apply(0, 1, 6'h3F);
        chk("t2_write", 192'(bus.write), 192'(3'b111));
        chk("t2_din", 192'(bus.din), 192'({32'hA2, 32'hA1, 32'hA0}));
        chk("t2_ptr", 192'(bus.ptr), 192'(3));
        chk("t2_gnt1", 192'(bus.req_gnt), 192'(6'b111000));
        adv();

        apply(0, 1, 6'b000111);
        adv();
        apply(0, 1, 6'b100001);
        chk("t3_ptr", 192'(bus.ptr), 192'(3));
        chk("t3_gnt", 192'(bus.req_gnt), 192'(6'b100001));
        adv();
        apply(0, 0, 6'b000000);
        chk("t3_write", 192'(bus.write), 192'(3'b011));
        chk("t3_port0", 192'(bus.din[31:0]), 192'(32'hA5));
        chk("t3_port1", 192'(bus.din[63:32]), 192'(32'hA0));
        chk("t3_nptr", 192'(bus.ptr), 192'(1));
        adv();

        apply(0, 1, 6'b001000);
        adv();
        for (int i = 0; i < 3; i++) begin
            apply(0, 1, 6'b000000);
            chk("t4_gnt", 192'(bus.req_gnt), 192'(0));
            chk("t4_ptr", 192'(bus.ptr), 192'(4));
            chk("t4_write", 192'(bus.write), 192'((i == 0) ? 3'b001 : 3'b000));
            adv();
        end

        apply(0, 1, 6'h3F);
        chk("t5_gnt", 192'(bus.req_gnt), 192'(6'b110001));
        adv();
        apply(1, 1, 6'h3F);
        chk("t5_rst_gnt", 192'(bus.req_gnt), 192'(0));
        adv();
        apply(0, 1, 6'h3F);
        chk("t5_write", 192'(bus.write), 192'(0));
        chk("t5_din", 192'(bus.din), 192'(0));
        chk("t5_ptr", 192'(bus.ptr), 192'(0));
        chk("t5_gnt1", 192'(bus.req_gnt), 192'(6'b000111));
        adv();

        // Saturated load: each requester served every other cycle, three writes per cycle.
        foreach (gcount[r]) gcount[r] = 0;
        wtotal = 0;
        for (int c = 0; c < 10; c++) begin
            apply(0, 1, 6'h3F);
            chk("t6_pergnt", 192'($countones(bus.req_gnt)), 192'(3));
            for (int r = 0; r < NUMREQ; r++) gcount[r] += int'(bus.req_gnt[r]);
            wtotal += $countones(bus.write);
            adv();
        end
        for (int r = 0; r < NUMREQ; r++) chk("t6_fair", 192'(gcount[r]), 192'(5));
        chk("t6_writes", 192'(wtotal), 192'(30));

        // Randomized traffic with occasional reset and ready drops.
        for (int c = 0; c < 400; c++) begin
            for (int r = 0; r < NUMREQ; r++) bus.req_din[r*WIDTH +: WIDTH] = $urandom;
            apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), NUMREQ'($urandom));
            adv();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
